iterative_branch_comparator: RTL and testbench

- Parametrised, multi-cycle comparator for the branch unit. Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU on two WIDTH-bit operands.
- Scans CHUNK bits per cycle, MSB-first, and terminates early at the first differing chunk.
- Sits between the ID/EX operand latch and the branch-resolution logic, with valid/ready handshakes on both sides.
- Supersedes the fixed 64-bit signed-only less-than gate network: adds width/chunk parameters, unsigned and equality modes, and a branch-taken decision.

---
 rtl/iterative_branch_comparator.sv | 122 ++++++++++++
 tb/tb_iterative_branch_comparator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_branch_comparator.sv
// rtl/iterative_branch_comparator.sv - multi-cycle MSB-first chunked branch comparator
// Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, stopping at the first differing chunk.
module iterative_branch_comparator #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       funct3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             lt,
  output logic             eq,
  output logic             illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       f3_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] sign_flip;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_ne, chunk_lt, last_chunk;
  logic             accept, resolve;

  // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
  assign sign_flip  = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};

  // Operands are shifted left each cycle, so the chunk under test is always the top one.
  assign a_chunk    = a_q[WIDTH-1 -: CHUNK];
  assign b_chunk    = b_q[WIDTH-1 -: CHUNK];
  assign chunk_ne   = (a_chunk != b_chunk);
  assign chunk_lt   = (a_chunk < b_chunk);
  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign accept     = (state_q == IDLE) && in_valid && !flush;
  assign resolve    = (state_q == SCAN) && !flush && (chunk_ne || last_chunk);

  function automatic logic decide(input logic [2:0] f3, input logic lt_v, input logic eq_v);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:         t = eq_v;
      3'b001:         t = ~eq_v;
      3'b100, 3'b110: t = lt_v;
      3'b101, 3'b111: t = ~lt_v;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: begin
        if (flush)        state_d = IDLE;
        else if (resolve) state_d = DONE;
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers only load on the resolving cycle, so they hold outside DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      k_q     <= '0;
      taken   <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      a_q  <= rs1 ^ sign_flip;
      b_q  <= rs2 ^ sign_flip;
      f3_q <= funct3;
      k_q  <= '0;
    end else if (state_q == SCAN && !flush) begin
      if (resolve) begin
        lt      <= chunk_ne & chunk_lt;
        eq      <= ~chunk_ne;
        taken   <= decide(f3_q, chunk_ne & chunk_lt, ~chunk_ne);
        illegal <= (f3_q[2:1] == 2'b01);
      end else begin
        a_q <= a_q << CHUNK;
        b_q <= b_q << CHUNK;
        k_q <= k_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iterative_branch_comparator.sv
// tb/tb_iterative_branch_comparator.sv - scoreboard bench for iterative_branch_comparator
module tb_iterative_branch_comparator;

  localparam int W = 64;
  localparam int C = 8;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] rs1, rs2;
  logic [2:0]   funct3;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic         taken, lt, eq, illegal;

  iterative_branch_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .lt(lt), .eq(eq), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lt;
    logic eq;
    logic taken;
    logic illegal;
    int   lat;
    int   acc;
    int   hold;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] f3, input int hold);
    exp_t e;
    e.eq = (a == b);
    e.lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    e.lat = N;
    for (int i = 0; i < N; i++) begin
      if (((a >> (W - C * (i + 1))) & 64'hFF) != ((b >> (W - C * (i + 1))) & 64'hFF)) begin
        e.lat = i + 1;
        break;
      end
    end
    case (f3)
      3'b000:         e.taken = e.eq;
      3'b001:         e.taken = !e.eq;
      3'b100, 3'b110: e.taken = e.lt;
      3'b101, 3'b111: e.taken = !e.lt;
      default:        e.taken = 1'b0;
    endcase
    e.illegal = (f3 == 3'b010) || (f3 == 3'b011);
    e.hold = hold;
    e.acc = 0;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f3,
                       input int hold, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    rs1 = a; rs2 = b; funct3 = f3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e = model(a, b, f3, hold);
      e.acc = cyc;
      q.push_back(e);
    end
    in_valid = 1'b0;
    rs1 = {$urandom, $urandom};
    rs2 = {$urandom, $urandom};
    funct3 = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready || out_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 0, 1);
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  initial begin
    exp_t e;
    int   hold;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
          out_ready = 1'b1;
          @(posedge clk);
          #1;
          out_ready = 1'b0;
        end else begin
          e = q.pop_front();
          chk("lt", lt, e.lt);
          chk("eq", eq, e.eq);
          chk("taken", taken, e.taken);
          chk("illegal", illegal, e.illegal);
          chk("latency", cyc - e.acc, e.lat);
          hold = (e.hold < 0) ? $urandom_range(0, 3) : e.hold;
          for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_taken", taken, e.taken);
            chk("hold_lt", lt, e.lt);
            chk("hold_eq", eq, e.eq);
            chk("hold_illegal", illegal, e.illegal);
          end
          out_ready = 1'b1;
          @(posedge clk);
          #1;
          out_ready = 1'b0;
          chk("consume_out_valid", out_valid, 0);
          chk("consume_in_ready", in_ready, 1);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] a, b, m, v;
    int           d;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    rs1 = '0; rs2 = '0; funct3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_lt", lt, 0);
    chk("rst_eq", eq, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b100, 0, 1);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b110, 0, 1);
    issue(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'b000, 0, 1);
    issue(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'b001, 0, 1);
    issue(64'h100, 64'h200, 3'b101, 0, 1);
    issue(64'h100, 64'h200, 3'b010, 0, 1);
    issue(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b111, 5, 1);

    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom};
      d = $urandom_range(0, N);
      b = a;
      if (d < N) begin
        m = {W{1'b1}} >> (C * d);
        v = {$urandom, $urandom};
        b = (a & ~m) | (v & m);
      end
      issue(a, b, 3'($urandom), -1, 1);
    end
    wait_idle();

    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_no_accept", in_ready, 1);

    issue(64'h55, 64'h55, 3'b000, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_scan_in_ready", in_ready, 1);
    chk("flush_scan_out_valid", out_valid, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("flush_no_result", out_valid, 0);
    end
    issue(64'h7, 64'h9, 3'b100, -1, 1);
    wait_idle();

    issue(64'hABCD, 64'hABCD, 3'b000, 0, 1);
    wait_idle();
    issue(64'hABCD, 64'hABCD, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_taken", taken, 0);
    chk("arst_eq", eq, 0);
    chk("arst_lt", lt, 0);
    chk("arst_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arst_no_result", out_valid, 0);
    end
    issue(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, -1, 1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
